// File: rtl/ibex_fetch_align_buffer.sv
// Fetch alignment buffer: queues word-aligned fetch responses and presents
// whole RV32IC instructions (16- or 32-bit) with their PC to the IF stage.
// A redirect (clear_i) flushes every queued word and restarts at addr_i.
module ibex_fetch_align_buffer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic [31:0]                    addr_i,
    input  logic                           in_valid_i,
    input  logic [31:0]                    in_rdata_i,
    input  logic                           in_err_i,
    output logic [$clog2(DEPTH+1)-1:0]     space_o,
    output logic                           fetch_valid_o,
    input  logic                           fetch_ready_i,
    output logic [31:0]                    fetch_rdata_o,
    output logic [31:0]                    fetch_pc_o,
    output logic                           fetch_err_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Word queue, entry 0 is the oldest; r_count says how many are valid.
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_err;
    logic [CW-1:0]    r_count;
    logic [31:0]      r_pc;

    logic        w_v0;
    logic        w_v1;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic        w_err;
    logic        w_compressed;
    logic        w_pop;
    logic        w_pop_word;
    logic        w_push;
    logic [CW-1:0] w_wr_idx;
    logic [31:0] w_shift_data [DEPTH];
    logic [DEPTH-1:0] w_shift_err;

    assign w_v0 = (r_count != '0);
    assign w_v1 = (r_count >= CW'(2));

    // Realign the head of the queue into one instruction.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    always_comb begin
        w_rdata = r_data[0];
        w_valid = w_v0;
        w_err   = r_err[0];
        if (r_pc[1]) begin
            // Upper half of entry0 is the low half of the instruction; the
            // high half comes from entry1 only if it is uncompressed.
            w_rdata = {r_data[1][15:0], r_data[0][31:16]};
            if (r_data[0][17:16] == 2'b11) begin
                // A faulting entry0 is reported at once instead of waiting for
                // entry1, which may never arrive after a bus error.
                w_valid = w_v0 & (w_v1 | r_err[0]);
                w_err   = r_err[0] | (w_v1 & r_err[1]);
            end
        end
    end

    assign w_compressed = (w_rdata[1:0] != 2'b11);

    // The redirect cycle never hands out an instruction.
    assign fetch_valid_o = w_valid & ~clear_i;
    assign fetch_rdata_o = w_rdata;
    assign fetch_err_o   = fetch_valid_o & w_err;
    assign fetch_pc_o    = r_pc;
    assign space_o       = CW'(DEPTH) - r_count;

    // An aligned compressed instruction leaves the upper half for the next one.
    assign w_pop      = fetch_valid_o & fetch_ready_i;
    assign w_pop_word = w_pop & (r_pc[1] | ~w_compressed);

    // A full queue still takes a word when the same cycle frees one; a
    // genuine overflow drops the word.
    assign w_push   = in_valid_i & ~clear_i & ((r_count != CW'(DEPTH)) | w_pop_word);
    assign w_wr_idx = r_count - CW'(w_pop_word);

    // Queue contents after dequeuing the oldest word.
    always_comb begin
        w_shift_data = r_data;
        w_shift_err  = r_err >> 1;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            w_shift_data[i] = r_data[i + 1];
        end
    end

    // Queue storage: shift on dequeue, write the arriving word behind the last valid one.
    // NOTE: the data words carry no reset; r_count alone defines which entries
    // are meaningful, so resetting the storage would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_push && (CW'(i) == w_wr_idx)) begin
                r_data[i] <= in_rdata_i;
                r_err[i]  <= in_err_i;
            end else if (w_pop_word) begin
                r_data[i] <= w_shift_data[i];
                r_err[i]  <= w_shift_err[i];
            end
        end
    end

    // Occupancy and next-instruction PC; clear has priority over push and pop.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
            r_pc    <= '0;
        end else if (clear_i) begin
            r_count <= '0;
            r_pc    <= addr_i & ~32'd1;
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop_word);
            if (w_pop) begin
                r_pc <= r_pc + (w_compressed ? 32'd2 : 32'd4);
            end
        end
    end

endmodule

// File: tb/tb_ibex_fetch_align_buffer.sv
// Directed self-checking bench for ibex_fetch_align_buffer (DEPTH = 2).
module tb_ibex_fetch_align_buffer;

    localparam int unsigned DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        in_valid_i = 1'b0;
    logic [31:0] in_rdata_i = '0;
    logic        in_err_i = 1'b0;
    logic [1:0]  space_o;
    logic        fetch_valid_o;
    logic        fetch_ready_i = 1'b0;
    logic [31:0] fetch_rdata_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    ibex_fetch_align_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .addr_i        (addr_i),
        .in_valid_i    (in_valid_i),
        .in_rdata_i    (in_rdata_i),
        .in_err_i      (in_err_i),
        .space_o       (space_o),
        .fetch_valid_o (fetch_valid_o),
        .fetch_ready_i (fetch_ready_i),
        .fetch_rdata_o (fetch_rdata_o),
        .fetch_pc_o    (fetch_pc_o),
        .fetch_err_o   (fetch_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // A push into a full queue must always coincide with a handshake.
    always @(negedge clk_i) begin
        if (rst_ni && in_valid_i && !clear_i && space_o == 2'd0)
            check("no_overflow", {31'd0, fetch_valid_o & fetch_ready_i}, 32'd1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_clear(input logic [31:0] a);
        clear_i = 1'b1;
        addr_i  = a;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic do_push(input logic [31:0] d, input logic e);
        in_valid_i = 1'b1;
        in_rdata_i = d;
        in_err_i   = e;
        tick();
        in_valid_i = 1'b0;
        in_err_i   = 1'b0;
    endtask

    task automatic do_pop();
        fetch_ready_i = 1'b1;
        tick();
        fetch_ready_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_valid", {31'd0, fetch_valid_o}, 32'd0);
        check("rst_pc",    fetch_pc_o, 32'h0);
        check("rst_err",   {31'd0, fetch_err_o}, 32'd0);
        check("rst_space", {30'd0, space_o}, 32'd2);
        rst_ni = 1'b1;
        tick();

        // 1 Aligned uncompressed
        do_clear(32'h80);
        do_push(32'h00A00093, 1'b0);
        check("t1_valid", {31'd0, fetch_valid_o}, 32'd1);
        check("t1_pc",    fetch_pc_o, 32'h80);
        check("t1_rdata", fetch_rdata_o, 32'h00A00093);
        check("t1_space", {30'd0, space_o}, 32'd1);
        do_pop();
        check("t1_pop_pc",    fetch_pc_o, 32'h84);
        check("t1_pop_valid", {31'd0, fetch_valid_o}, 32'd0);
        check("t1_pop_space", {30'd0, space_o}, 32'd2);

        // 2 Two compressed instructions in one word
        do_clear(32'h80);
        do_push(32'h45054585, 1'b0);
        check("t2_pc0",    fetch_pc_o, 32'h80);
        check("t2_rd0",    {16'd0, fetch_rdata_o[15:0]}, 32'h4585);
        do_pop();
        check("t2_valid1", {31'd0, fetch_valid_o}, 32'd1);
        check("t2_pc1",    fetch_pc_o, 32'h82);
        check("t2_rd1",    {16'd0, fetch_rdata_o[15:0]}, 32'h4505);
        check("t2_space1", {30'd0, space_o}, 32'd1);
        do_pop();
        check("t2_valid2", {31'd0, fetch_valid_o}, 32'd0);
        check("t2_pc2",    fetch_pc_o, 32'h84);
        check("t2_space2", {30'd0, space_o}, 32'd2);

        // 3 Unaligned instruction spanning two words
        do_clear(32'h102);
        do_push(32'h00930001, 1'b0);
        check("t3_wait",  {31'd0, fetch_valid_o}, 32'd0);
        do_push(32'h000000A0, 1'b0);
        check("t3_valid", {31'd0, fetch_valid_o}, 32'd1);
        check("t3_pc",    fetch_pc_o, 32'h102);
        check("t3_rdata", fetch_rdata_o, 32'h00A00093);
        do_pop();
        check("t3_pop_pc",    fetch_pc_o, 32'h106);
        check("t3_pop_space", {30'd0, space_o}, 32'd1);

        // 4 Occupancy, push into a full queue while popping
        do_clear(32'h0);
        do_push(32'h00000013, 1'b0);
        do_push(32'h00100093, 1'b0);
        check("t4_full", {30'd0, space_o}, 32'd0);
        in_valid_i    = 1'b1;
        in_rdata_i    = 32'h00200113;
        fetch_ready_i = 1'b1;
        tick();
        in_valid_i    = 1'b0;
        fetch_ready_i = 1'b0;
        check("t4_space_still0", {30'd0, space_o}, 32'd0);
        check("t4_pc1",          fetch_pc_o, 32'h4);
        check("t4_rd1",          fetch_rdata_o, 32'h00100093);
        do_pop();
        check("t4_space1", {30'd0, space_o}, 32'd1);
        check("t4_pc2",    fetch_pc_o, 32'h8);
        check("t4_rd2",    fetch_rdata_o, 32'h00200113);

        // 5 Flush with a stale response in the clear cycle
        do_clear(32'h300);
        do_push(32'h00000013, 1'b0);
        do_push(32'h00100093, 1'b0);
        clear_i    = 1'b1;
        addr_i     = 32'h201;
        in_valid_i = 1'b1;
        in_rdata_i = 32'hDEADBEEF;
        #1;
        check("t5_valid_in_clear", {31'd0, fetch_valid_o}, 32'd0);
        tick();
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        check("t5_space", {30'd0, space_o}, 32'd2);
        check("t5_pc",    fetch_pc_o, 32'h200);
        check("t5_empty", {31'd0, fetch_valid_o}, 32'd0);

        // 6 Errors
        do_clear(32'h102);
        do_push(32'h00930001, 1'b0);
        do_push(32'h000000A0, 1'b1);
        check("t6_err1_valid", {31'd0, fetch_valid_o}, 32'd1);
        check("t6_err1",       {31'd0, fetch_err_o}, 32'd1);
        do_clear(32'h102);
        do_push(32'h00930001, 1'b1);
        check("t6_err0_valid", {31'd0, fetch_valid_o}, 32'd1);
        check("t6_err0",       {31'd0, fetch_err_o}, 32'd1);
        do_clear(32'h80);
        do_push(32'h00A00093, 1'b0);
        check("t6_noerr", {31'd0, fetch_err_o}, 32'd0);

        // Asynchronous reset mid-stream
        do_push(32'h00100093, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, fetch_valid_o}, 32'd0);
        check("t6_rst_pc",    fetch_pc_o, 32'h0);
        check("t6_rst_err",   {31'd0, fetch_err_o}, 32'd0);
        check("t6_rst_space", {30'd0, space_o}, 32'd2);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
